instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Writer side of the processor's instruction-memory write port.
- Accepts a byte stream through a valid/ready handshake and assembles little-endian 32-bit words.
- Drives instr_in, instr_wr_addr and instr_wr_en into the pipelined core.
- Holds the core in reset until a complete program image has been written. Replaces testbench-driven memory filling for bring-up and FPGA boot.

Parameters:
- WIDTH, 32: bits per instruction word; fixed at 32.
- SIZE, 64: instruction memory depth in words; must match the core.
- LOGSIZE (localparam), $clog2(SIZE): word-index width.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load session.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader accepts a byte this cycle.
- instr_in  output  WIDTH  assembled word to the instruction memory.
- instr_wr_addr  output  LOGSIZE+2  byte address of the word; bits [1:0] are always 0.
- instr_wr_en  output  1  one-cycle write strobe.
- core_hold  output  1  high means the core must be held in reset.
- done  output  1  last load completed successfully.
- error  output  1  last load was rejected.
- words_written  output  LOGSIZE+1  count of words written in the current/last session.

Behaviour:
- Reset (reset low, asynchronous):
  - State IDLE.
  - core_hold=1.
  - byte_ready=0, instr_wr_en=0, done=0, error=0.
  - instr_in=0, instr_wr_addr=0, words_written=0.
  - Assembly register and byte counter cleared.
  - Reset asserted mid-session aborts the session; no partial word is written.
- Byte transfer: a byte is accepted on a rising edge where byte_valid && byte_ready. byte_ready is a function of state only and never depends on byte_valid.
- States:
  - IDLE: byte_ready=0. On start go to LEN0; in the same edge set core_hold=1, clear done, error, words_written and the byte counter.
  - LEN0: byte_ready=1. The accepted byte becomes N[7:0]; go to LEN1.
  - LEN1: byte_ready=1. The accepted byte becomes N[15:8]. Then:
    - N==0: go to DONE.
    - N>SIZE: set error=1 and go to IDLE; core_hold stays 1 and no writes occur.
    - Otherwise go to DATA.
  - DATA: byte_ready=1.
    - The k-th accepted byte of a word (k=0..3) is placed in bits [8k+7:8k] (little-endian).
    - On the 4th byte, the completed word is registered into instr_in and instr_wr_addr = words_written*4. instr_wr_en=1 for exactly the next cycle; words_written increments in that same cycle.
    - No stall is needed: bytes for the next word may be accepted in the write-strobe cycle, and instr_in/instr_wr_addr stay stable while instr_wr_en=1.
    - After the write of word N-1, go to DONE.
  - DONE: byte_ready=0, done=1, core_hold=0. Hold until start, which re-enters LEN0 exactly as from IDLE.
- start while in LEN0, LEN1 or DATA is ignored.
- byte_valid in IDLE or DONE is ignored; no byte is consumed.
- Address wrap cannot occur because N<=SIZE is enforced. The highest address written is (SIZE-1)*4.
- instr_wr_en is never asserted outside the cycle that follows a completed word.

Test Plan:
- Basic load:
  - Stimulus: reset, start, stream 02 00 | 13 05 10 00 | 93 05 20 00, byte_valid held high.
  - Required response: instr_wr_en pulses twice, writing 0x00100513 @ addr 0x00 and 0x00200593 @ addr 0x04. Then done=1, core_hold=0, words_written=2.
- Handshake gaps:
  - Stimulus: same stream as the basic load, with byte_valid deasserted for random 0–5 cycle gaps.
  - Required response: identical writes and addresses; no byte is lost or duplicated.
- Oversize length:
  - Stimulus: length 41 00 (N=65) with SIZE=64.
  - Required response: error=1, state back in IDLE, zero write strobes, core_hold=1, byte_ready=0.
- Zero length and full depth:
  - N=0: done=1 with no strobe.
  - N=64: the last write is at addr 0xFC, words_written=64.
- Reset mid-word:
  - Stimulus: assert reset after 2 data bytes of word 1.
  - Required response: all outputs return to reset values immediately (asynchronous); no strobe for the partial word.
  - Follow-up: a new start plus a full stream loads correctly from addr 0.
- Reload and ignored start:
  - Stimulus: pulse start during DATA, then complete the load, then pulse start again from DONE.
  - Required response: the start during DATA has no effect. The start from DONE clears done, raises core_hold and accepts a new length.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction-memory write port. Takes a 16-bit length N
// followed by N little-endian words, writes them from address 0 and releases core reset.
module instr_mem_loader #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SIZE = 64,
  localparam int unsigned LOGSIZE = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic [WIDTH-1:0]   instr_in,
  output logic [LOGSIZE+1:0] instr_wr_addr,
  output logic               instr_wr_en,
  output logic               core_hold,
  output logic               done,
  output logic               error,
  output logic [LOGSIZE:0]   words_written
);

  typedef enum logic [2:0] {StIdle, StLen0, StLen1, StData, StDone} state_e;

  state_e             state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [WIDTH-9:0]   asm_q, asm_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [WIDTH-1:0]   instr_q, instr_d;
  logic [LOGSIZE+1:0] addr_q, addr_d;
  logic               wr_en_q, wr_en_d;
  logic [LOGSIZE:0]   words_q, words_d;
  logic               error_q, error_d;
  logic [15:0]        len_full;
  logic               accept;

  assign byte_ready = (state_q == StLen0) || (state_q == StLen1) || (state_q == StData);
  assign accept     = byte_valid && byte_ready;
  assign len_full   = {byte_in, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    asm_d      = asm_q;
    byte_cnt_d = byte_cnt_q;
    instr_d    = instr_q;
    addr_d     = addr_q;
    wr_en_d    = 1'b0;
    words_d    = words_q;
    error_d    = error_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StLen0;
          error_d    = 1'b0;
          words_d    = '0;
          byte_cnt_d = '0;
          asm_d      = '0;
        end
      end
      StLen0: begin
        if (accept) begin
          len_d[7:0] = byte_in;
          state_d    = StLen1;
        end
      end
      StLen1: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == 16'd0) begin
            state_d = StDone;
          end else if (32'(len_full) > SIZE) begin
            error_d = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Next word's bytes may arrive during the strobe; instr/addr are separate registers.
            instr_d = {byte_in, asm_q};
            addr_d  = {words_q[LOGSIZE-1:0], 2'b00};
            wr_en_d = 1'b1;
            words_d = words_q + 1'b1;
            if (16'(words_d) == len_q) begin
              state_d = StDone;
            end
          end else begin
            asm_d[8*byte_cnt_q +: 8] = byte_in;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      asm_q      <= '0;
      byte_cnt_q <= '0;
      instr_q    <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      words_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      asm_q      <= asm_d;
      byte_cnt_q <= byte_cnt_d;
      instr_q    <= instr_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      words_q    <= words_d;
      error_q    <= error_d;
    end
  end

  assign done          = (state_q == StDone);
  assign core_hold     = !done;
  assign error         = error_q;
  assign instr_in      = instr_q;
  assign instr_wr_addr = addr_q;
  assign instr_wr_en   = wr_en_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: expected writes are queued as bytes are driven and
// matched against each write strobe.
module tb_instr_mem_loader;

  localparam int SIZE = 64;
  localparam int LOGSIZE = 6;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [7:0]         byte_in = 8'h00;
  logic               byte_valid = 1'b0;
  logic               byte_ready;
  logic [31:0]        instr_in;
  logic [LOGSIZE+1:0] instr_wr_addr;
  logic               instr_wr_en;
  logic               core_hold;
  logic               done;
  logic               error;
  logic [LOGSIZE:0]   words_written;

  instr_mem_loader #(.WIDTH(32), .SIZE(SIZE)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .instr_in      (instr_in),
    .instr_wr_addr (instr_wr_addr),
    .instr_wr_en   (instr_wr_en),
    .core_hold     (core_hold),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          strobes = 0;
  int          s0;
  logic [31:0] last_addr = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (instr_wr_en === 1'b1) begin
      wr_t e;
      strobes++;
      last_addr = 32'(instr_wr_addr);
      chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_data", instr_in, e.data);
        chk("wr_addr", 32'(instr_wr_addr), e.addr);
      end
    end
  end

  task automatic push_exp(input logic [31:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_bound", 32'(n < 50), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int k = 0; k < 4; k++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_bound", 32'(n < 200), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_core_hold"}, 32'(core_hold), 32'd1);
    chk({pfx, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({pfx, "_wr_en"}, 32'(instr_wr_en), 32'd0);
    chk({pfx, "_done"}, 32'(done), 32'd0);
    chk({pfx, "_error"}, 32'(error), 32'd0);
    chk({pfx, "_instr_in"}, instr_in, 32'd0);
    chk({pfx, "_addr"}, 32'(instr_wr_addr), 32'd0);
    chk({pfx, "_words"}, 32'(words_written), 32'd0);
  endtask

  initial begin
    logic [31:0] w;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);

    // Basic load, byte_valid held high
    pulse_start();
    push_exp(32'h00, 32'h00100513);
    push_exp(32'h04, 32'h00200593);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h00100513, 0);
    send_word(32'h00200593, 0);
    wait_done();
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_core_hold", 32'(core_hold), 32'd0);
    chk("basic_words", 32'(words_written), 32'd2);
    chk("basic_strobes", 32'(strobes), 32'd2);
    chk("basic_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("basic_ready", 32'(byte_ready), 32'd0);

    // Bytes offered in DONE are ignored
    byte_in = 8'hFF;
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    chk("done_ign_words", 32'(words_written), 32'd2);
    chk("done_ign_done", 32'(done), 32'd1);
    chk("done_ign_strobes", 32'(strobes), 32'd2);

    // Handshake gaps
    s0 = strobes;
    pulse_start();
    push_exp(32'h00, 32'h00100513);
    push_exp(32'h04, 32'h00200593);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    send_byte(8'h02);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    send_byte(8'h00);
    send_word(32'h00100513, 5);
    send_word(32'h00200593, 5);
    wait_done();
    chk("gap_strobes", 32'(strobes - s0), 32'd2);
    chk("gap_words", 32'(words_written), 32'd2);
    chk("gap_sb_empty", 32'(exp_q.size()), 32'd0);

    // Oversize length N=65
    s0 = strobes;
    pulse_start();
    send_byte(8'h41);
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    chk("over_error", 32'(error), 32'd1);
    chk("over_ready", 32'(byte_ready), 32'd0);
    chk("over_core_hold", 32'(core_hold), 32'd1);
    chk("over_done", 32'(done), 32'd0);
    chk("over_strobes", 32'(strobes - s0), 32'd0);
    chk("over_words", 32'(words_written), 32'd0);

    // Zero length
    pulse_start();
    chk("zero_error_clr", 32'(error), 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_done();
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_strobes", 32'(strobes - s0), 32'd0);
    chk("zero_words", 32'(words_written), 32'd0);

    // Full depth N=64
    s0 = strobes;
    pulse_start();
    send_byte(8'h40);
    send_byte(8'h00);
    for (int i = 0; i < SIZE; i++) begin
      w = {8'(i), 8'hA5, 8'(~i), 8'(i * 3)};
      push_exp(32'(i * 4), w);
      send_word(w, 0);
    end
    wait_done();
    chk("full_words", 32'(words_written), 32'd64);
    chk("full_last_addr", last_addr, 32'hFC);
    chk("full_strobes", 32'(strobes - s0), 32'd64);
    chk("full_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("full_done", 32'(done), 32'd1);

    // Reset mid-word
    s0 = strobes;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #1 reset = 1'b0;
    #1 check_reset_vals("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_strobes", 32'(strobes - s0), 32'd0);
    pulse_start();
    push_exp(32'h00, 32'hDEADBEEF);
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'hDEADBEEF, 0);
    wait_done();
    chk("rst_follow_words", 32'(words_written), 32'd1);
    chk("rst_follow_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("rst_follow_strobes", 32'(strobes - s0), 32'd1);

    // Start during DATA is ignored; start from DONE reloads
    pulse_start();
    push_exp(32'h00, 32'h11223344);
    push_exp(32'h04, 32'h55667788);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h11223344, 0);
    send_byte(8'h88);
    pulse_start();
    chk("ign_start_ready", 32'(byte_ready), 32'd1);
    chk("ign_start_words", 32'(words_written), 32'd1);
    send_byte(8'h77);
    send_byte(8'h66);
    send_byte(8'h55);
    wait_done();
    chk("ign_start_words_end", 32'(words_written), 32'd2);
    chk("ign_start_sb_empty", 32'(exp_q.size()), 32'd0);
    pulse_start();
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_core_hold", 32'(core_hold), 32'd1);
    chk("reload_ready", 32'(byte_ready), 32'd1);
    chk("reload_words", 32'(words_written), 32'd0);
    push_exp(32'h00, 32'hCAFEF00D);
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'hCAFEF00D, 0);
    wait_done();
    chk("reload_done_end", 32'(done), 32'd1);
    chk("reload_words_end", 32'(words_written), 32'd1);
    chk("reload_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
